// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
// Holds the receiver state enum, data width and default bit period.
package uart_rx_pkg;

  localparam int DATA_BITS      = 8;
  localparam int BIT_CYCLES_DEF = 434;

  typedef enum logic [2:0] {
    IDLE_S   = 3'd0,
    START_S  = 3'd1,
    DATA_S   = 3'd2,
    PARITY_S = 3'd3,
    STOP_S   = 3'd4,
    DONE_S   = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Bit-period counter with synchronous clear; flags half and full bit.
// Ports: clk, rst (async active-low), clr, half_tick, bit_tick.
module uart_rx_baud_tick #(
  parameter int BIT_CYCLES = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half_tick,
  output logic bit_tick
);

  localparam int CW = $clog2(BIT_CYCLES);

  logic [CW-1:0] cnt;

  assign half_tick = (cnt == CW'(BIT_CYCLES / 2 - 1));
  assign bit_tick  = (cnt == CW'(BIT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1/8E1/8O1 UART receiver with sticky data/error flags.
// Ports: clk, rst, rx_i, rx_flag_clr_i, rx_data_o, flags, rx_busy_o, rx_state_out.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_i,
  input  logic            rx_flag_clr_i,
  output logic [7:0]      rx_data_o,
  output logic            rx_flag_o,
  output logic            parity_err_o,
  output logic            frame_err_o,
  output logic            overrun_err_o,
  output logic            rx_busy_o,
  output rx_state_t       rx_state_out
);

  rx_state_t state;
  rx_state_t state_n;

  logic           rx_m;
  logic           rx_s;
  logic           rx_prev;
  logic           half_tick;
  logic           bit_tick;
  logic           cnt_clr;
  logic [7:0]     shift_reg;
  logic [2:0]     bit_idx;
  logic           par_bad;
  logic           stop_bad;

  // Idle-high synchronizer; rx_prev gives a falling-edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx_i;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // Counter restarts on every state change.
  assign cnt_clr = (state_n != state);

  uart_rx_baud_tick #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .half_tick(half_tick),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE_S;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE_S: begin
        if (rx_prev && !rx_s) state_n = START_S;
      end
      START_S: begin
        if (half_tick) state_n = rx_s ? IDLE_S : DATA_S;
      end
      DATA_S: begin
        if (bit_tick && bit_idx == 3'd7)
          state_n = PARITY_EN ? PARITY_S : STOP_S;
      end
      PARITY_S: begin
        if (bit_tick) state_n = STOP_S;
      end
      STOP_S: begin
        if (bit_tick) state_n = DONE_S;
      end
      DONE_S: begin
        state_n = IDLE_S;
      end
      default: state_n = IDLE_S;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      par_bad   <= 1'b0;
      stop_bad  <= 1'b0;
    end else begin
      if (state == IDLE_S) begin
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (state != DATA_S) begin
        bit_idx <= '0;
      end else if (bit_tick) begin
        shift_reg <= {rx_s, shift_reg[7:1]};
        bit_idx   <= bit_idx + 1'b1;
      end
      if (state == PARITY_S && bit_tick)
        par_bad <= ^shift_reg ^ rx_s ^ PARITY_ODD;
      if (state == STOP_S && bit_tick)
        stop_bad <= ~rx_s;
    end
  end

  // A completed byte beats a same-cycle clear; the clear only
  // drops the history, so the new byte's errors survive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_o     <= '0;
      rx_flag_o     <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else if (state == DONE_S) begin
      rx_data_o     <= shift_reg;
      rx_flag_o     <= 1'b1;
      parity_err_o  <= (parity_err_o & ~rx_flag_clr_i) | par_bad;
      frame_err_o   <= (frame_err_o & ~rx_flag_clr_i) | stop_bad;
      overrun_err_o <= rx_flag_clr_i ? 1'b0
                                     : (overrun_err_o | rx_flag_o);
    end else if (rx_flag_clr_i) begin
      rx_flag_o     <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end
  end

  assign rx_busy_o    = (state != IDLE_S);
  assign rx_state_out = state;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- RS232 receiver: the receive counterpart to the team's UART transmitter in the RISC-V UART peripheral.
- Format is 8N1, or 8E1/8O1 when parity is enabled. Data is LSB-first, idle line high.
- Contains the input synchronizer, baud timing, mid-bit sampling, shift register, and error/status flags.
- A received byte is held in an output register and a flag is raised until the CPU-side logic clears it.

Parameters:
- BIT_CYCLES, 434, clk cycles per bit (50 MHz / 115200); must be >= 8.
- PARITY_EN, 1, 1 = one parity bit after the data bits, 0 = none.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rx_i  input  1  asynchronous serial line
- rx_flag_clr_i  input  1  single-cycle clear of rx_flag_o and the error flags
- rx_data_o  output  8  last received byte
- rx_flag_o  output  1  byte available (sticky)
- parity_err_o  output  1  parity mismatch on last byte (sticky)
- frame_err_o  output  1  stop bit sampled low (sticky)
- overrun_err_o  output  1  new byte completed while rx_flag_o was still set (sticky)
- rx_busy_o  output  1  high in every state except IDLE_S
- rx_state_out  output  rx_state_t  debug: current state

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE_S; all outputs 0; synchronizer flops set to 1; counters cleared.
- Synchronizer: rx_i passes through two flops to give rx_s; a third flop gives rx_prev.
- Start detection is on the edge rx_prev = 1, rx_s = 0 only. A line held low never re-triggers.
- Baud counter: 0 .. BIT_CYCLES-1. Cleared on every state entry.
  - half_tick = (cnt == BIT_CYCLES/2 - 1).
  - bit_tick = (cnt == BIT_CYCLES - 1).
- States and transitions:
  - IDLE_S -> START_S on start edge.
  - START_S: at half_tick, if rx_s = 0 go to DATA_S; otherwise go to IDLE_S (glitch rejected, no flag change). This re-aligns sampling to mid-bit.
  - DATA_S: at each bit_tick:
    - shift_reg <= {rx_s, shift_reg[7:1]}, and bit_idx increments.
    - After the 8th sample (bit_idx == 7), go to PARITY_S if PARITY_EN, else STOP_S.
  - PARITY_S: at bit_tick, par_bad = (^shift_reg ^ rx_s ^ PARITY_ODD); go to STOP_S.
  - STOP_S: at bit_tick, stop_bad = ~rx_s; go to DONE_S.
  - DONE_S: lasts one cycle; updates outputs (below); goes to IDLE_S.
- Output update in DONE_S:
  - rx_data_o <= shift_reg.
  - rx_flag_o <= 1.
  - parity_err_o |= par_bad.
  - frame_err_o |= stop_bad.
  - overrun_err_o |= rx_flag_o (value before the update).
- rx_data_o is updated even on a framing or parity error, so software can discard the byte.
- Latency: rx_flag_o rises 2 clocks after the stop-bit sample cycle (DONE_S registers the outputs).
- rx_flag_clr_i clears rx_flag_o and all error flags. If it coincides with the DONE_S update, the set wins:
  - rx_flag_o = 1.
  - Errors of the new byte are kept.
  - overrun_err_o = 0.
- After a framing error (line held low / break), no new start is detected until rx_s has returned high for at least one cycle.
- bit_idx is 3 bits wide; it is cleared on DATA_S entry and does not wrap within a frame.
- Reset mid-frame aborts immediately. A partial byte is never flagged.

Decomposition:
- UART_pkg gets the enum rx_state_t {IDLE_S, START_S, DATA_S, PARITY_S, STOP_S, DONE_S}, plus localparams DATA_BITS = 8 and the default BIT_CYCLES.
- One sub-module, uart_rx_baud_tick: counter with sync clear, parameter BIT_CYCLES, outputs half_tick and bit_tick.
- The FSM and datapath stay in uart_rx.

Test Plan (BIT_CYCLES = 16 for simulation):
- Send 0xA5 in 8E1 (parity 0, stop 1) -> rx_data_o = 0xA5, rx_flag_o = 1, all error flags 0, state returns to IDLE_S.
- Send 0x3C with the parity bit forced to 1 (even mode) -> rx_data_o = 0x3C, parity_err_o = 1, frame_err_o = 0.
- Send 0xFF with the stop bit held low for 3 bit times -> frame_err_o = 1; no second byte flagged until the line goes high and a new start edge arrives.
- Pulse rx_i low for 4 clocks (< half bit) -> START_S then IDLE_S, rx_flag_o stays 0, rx_busy_o back to 0.
- Send 0x11 then 0x22 without clearing -> rx_data_o = 0x22, overrun_err_o = 1. Then pulse rx_flag_clr_i -> all flags 0.
- Assert rst during DATA_S of 0x55 -> all outputs 0, IDLE_S. The next full frame 0x0F is received correctly.
